// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg: shared widths and ALU operand forwarding selects for the hazard unit.
// Revision: 1.0
`default_nettype none

package hazard_unit_pkg;

  localparam int REGW = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_stall_counter.sv
// stall_counter: saturating event counter with enable and asynchronous active-low reset.
// Revision: 1.0
`default_nettype none

module stall_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  output logic [CNTW-1:0] count
);

  localparam logic [CNTW-1:0] C_ONE = {{(CNTW-1){1'b0}}, 1'b1};

  logic [CNTW-1:0] r_count;

  // Holds at all-ones so a long stall run never wraps back to a small value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (en && (r_count != '1)) begin
      r_count <= r_count + C_ONE;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// hazard_unit: 5-stage MIPS forwarding/stall/flush control with load-use and branch stall counters.
// Revision: 1.0
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::fwd_sel_t,
         hazard_unit_pkg::FWD_RF,
         hazard_unit_pkg::FWD_WB,
         hazard_unit_pkg::FWD_MEM;
#(
  parameter int REGW = hazard_unit_pkg::REGW,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [REGW-1:0] WriteRegE,
  input  logic [REGW-1:0] WriteRegM,
  input  logic [REGW-1:0] WriteRegW,
  input  logic            RegWriteE,
  input  logic            RegWriteM,
  input  logic            RegWriteW,
  input  logic            MemtoRegE,
  input  logic            MemtoRegM,
  input  logic [REGW-1:0] rsD,
  input  logic [REGW-1:0] rtD,
  input  logic [REGW-1:0] rsE,
  input  logic [REGW-1:0] rtE,
  input  logic            BranchD,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  output logic            ForwardAD,
  output logic            ForwardBD,
  output logic [1:0]      ForwardAE,
  output logic [1:0]      ForwardBE,
  output logic [CNTW-1:0] LwStallCnt,
  output logic [CNTW-1:0] BrStallCnt
);

  fwd_sel_t fwd_a_e;
  fwd_sel_t fwd_b_e;
  logic     fwd_a_d;
  logic     fwd_b_d;
  logic     lwstall;
  logic     branchstall;
  logic     stall;

  // Memory stage wins over Writeback: it holds the younger result.
  always_comb begin
    fwd_a_e = FWD_RF;
    if ((rsE != '0) && (rsE == WriteRegM) && RegWriteM) begin
      fwd_a_e = FWD_MEM;
    end else if ((rsE != '0) && (rsE == WriteRegW) && RegWriteW) begin
      fwd_a_e = FWD_WB;
    end
  end

  always_comb begin
    fwd_b_e = FWD_RF;
    if ((rtE != '0) && (rtE == WriteRegM) && RegWriteM) begin
      fwd_b_e = FWD_MEM;
    end else if ((rtE != '0) && (rtE == WriteRegW) && RegWriteW) begin
      fwd_b_e = FWD_WB;
    end
  end

  // Writeback needs no path to Decode: the register file writes in the first half-cycle.
  always_comb begin
    fwd_a_d = (rsD != '0) && (rsD == WriteRegM) && RegWriteM;
    fwd_b_d = (rtD != '0) && (rtD == WriteRegM) && RegWriteM;
  end

  always_comb begin
    lwstall     = MemtoRegE && ((rtE == rsD) || (rtE == rtD));
    branchstall = BranchD &&
                  ((RegWriteE && ((WriteRegE == rsD) || (WriteRegE == rtD))) ||
                   (MemtoRegM && ((WriteRegM == rsD) || (WriteRegM == rtD))));
    stall       = lwstall || branchstall;
  end

  // Reset low masks every control output regardless of the pipeline fields.
  always_comb begin
    StallD    = reset && stall;
    StallF    = reset && stall;
    FlushE    = reset && stall;
    ForwardAD = reset && fwd_a_d;
    ForwardBD = reset && fwd_b_d;
    ForwardAE = reset ? fwd_a_e : FWD_RF;
    ForwardBE = reset ? fwd_b_e : FWD_RF;
  end

  stall_counter #(
    .CNTW (CNTW)
  ) u_lw_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (lwstall),
    .count (LwStallCnt)
  );

  stall_counter #(
    .CNTW (CNTW)
  ) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (branchstall),
    .count (BrStallCnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit: directed scoreboard bench for hazard_unit (16-bit and 2-bit counter builds).
// Revision: 1.0
`default_nettype none

module tb_hazard_unit;

  logic       clk;
  logic       reset;
  logic [4:0] WriteRegE, WriteRegM, WriteRegW;
  logic       RegWriteE, RegWriteM, RegWriteW;
  logic       MemtoRegE, MemtoRegM;
  logic [4:0] rsD, rtD, rsE, rtE;
  logic       BranchD;

  logic        StallF, StallD, FlushE, ForwardAD, ForwardBD;
  logic [1:0]  ForwardAE, ForwardBE;
  logic [15:0] LwStallCnt, BrStallCnt;

  logic        s_StallF, s_StallD, s_FlushE, s_ForwardAD, s_ForwardBD;
  logic [1:0]  s_ForwardAE, s_ForwardBE;
  logic [1:0]  s_LwStallCnt, s_BrStallCnt;

  typedef struct {
    string       tag;
    bit          is_cnt;
    logic [35:0] exp;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  logic [15:0] lw_exp = '0;
  logic [15:0] br_exp = '0;
  logic [1:0]  sat_lw_exp = '0;
  logic [1:0]  sat_br_exp = '0;

  hazard_unit #(.REGW(5), .CNTW(16)) dut (
    .clk(clk), .reset(reset),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .BranchD(BranchD),
    .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
    .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .LwStallCnt(LwStallCnt), .BrStallCnt(BrStallCnt)
  );

  hazard_unit #(.REGW(5), .CNTW(2)) dut_sat (
    .clk(clk), .reset(reset),
    .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MemtoRegM(MemtoRegM),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE), .BranchD(BranchD),
    .StallF(s_StallF), .StallD(s_StallD), .FlushE(s_FlushE),
    .ForwardAD(s_ForwardAD), .ForwardBD(s_ForwardBD),
    .ForwardAE(s_ForwardAE), .ForwardBE(s_ForwardBE),
    .LwStallCnt(s_LwStallCnt), .BrStallCnt(s_BrStallCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check();
    exp_t        e;
    logic [35:0] obs;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=empty expected=entry");
      return;
    end
    e = sb.pop_front();
    if (e.is_cnt) obs = {LwStallCnt, BrStallCnt, s_LwStallCnt, s_BrStallCnt};
    else          obs = {27'd0, StallF, StallD, FlushE, ForwardAD, ForwardBD, ForwardAE, ForwardBE};
    assert (obs === e.exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic push_ctrl(input string tag, input bit s, input bit fad, input bit fbd,
                           input logic [1:0] fae, input logic [1:0] fbe);
    exp_t e;
    e.tag    = tag;
    e.is_cnt = 1'b0;
    e.exp    = {27'd0, s, s, s, fad, fbd, fae, fbe};
    sb.push_back(e);
  endtask

  task automatic push_cnt(input string tag);
    exp_t e;
    e.tag    = {tag, "_cnt"};
    e.is_cnt = 1'b1;
    e.exp    = {lw_exp, br_exp, sat_lw_exp, sat_br_exp};
    sb.push_back(e);
  endtask

  // Called at a falling edge, inputs already driven.
  task automatic step(input string tag, input bit s, input bit fad, input bit fbd,
                      input logic [1:0] fae, input logic [1:0] fbe,
                      input bit lw_inc, input bit br_inc);
    push_ctrl(tag, s, fad, fbd, fae, fbe);
    #1 check();
    if (lw_inc) begin
      lw_exp = lw_exp + 16'd1;
      if (sat_lw_exp != 2'd3) sat_lw_exp = sat_lw_exp + 2'd1;
    end
    if (br_inc) begin
      br_exp = br_exp + 16'd1;
      if (sat_br_exp != 2'd3) sat_br_exp = sat_br_exp + 2'd1;
    end
    push_cnt(tag);
    @(posedge clk);
    #1 check();
  endtask

  task automatic idle();
    @(negedge clk);
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b0; MemtoRegM = 1'b0;
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    BranchD = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
    RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
    MemtoRegE = 1'b1; MemtoRegM = 1'b0;
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    BranchD = 1'b0;

    // Load-use condition present while in reset: outputs must stay masked.
    #3;
    push_ctrl("reset_ctrl", 1'b0, 1'b0, 1'b0, 2'b00, 2'b00);
    check();
    @(posedge clk); #1;
    push_cnt("reset");
    check();
    idle();
    reset = 1'b1;

    idle(); rsE = 5; WriteRegM = 5; RegWriteM = 1; WriteRegW = 5; RegWriteW = 1;
    step("fwd_a_mem_prio", 0, 0, 0, 2'b10, 2'b00, 0, 0);
    idle(); rsE = 5; WriteRegM = 5; RegWriteM = 0; WriteRegW = 5; RegWriteW = 1;
    step("fwd_a_wb", 0, 0, 0, 2'b01, 2'b00, 0, 0);
    idle(); rtE = 7; WriteRegM = 7; RegWriteM = 1; WriteRegW = 7; RegWriteW = 1;
    step("fwd_b_mem", 0, 0, 0, 2'b00, 2'b10, 0, 0);
    idle(); rtE = 7; WriteRegW = 7; RegWriteW = 1;
    step("fwd_b_wb", 0, 0, 0, 2'b00, 2'b01, 0, 0);
    idle(); RegWriteM = 1; RegWriteW = 1;
    step("zero_guard", 0, 0, 0, 2'b00, 2'b00, 0, 0);

    idle(); MemtoRegE = 1; rtE = 8; rtD = 8;
    step("lw_use_rt", 1, 0, 0, 2'b00, 2'b00, 1, 0);
    idle(); MemtoRegE = 1; rtE = 4; rsD = 4;
    step("lw_use_rs", 1, 0, 0, 2'b00, 2'b00, 1, 0);
    idle(); MemtoRegE = 1;
    step("lw_use_r0", 1, 0, 0, 2'b00, 2'b00, 1, 0);
    idle(); MemtoRegE = 1; rtE = 8; rsD = 1; rtD = 2;
    step("lw_no_match", 0, 0, 0, 2'b00, 2'b00, 0, 0);

    idle(); BranchD = 1; RegWriteE = 1; WriteRegE = 3; rsD = 3;
    step("br_alu_e", 1, 0, 0, 2'b00, 2'b00, 0, 1);
    idle(); BranchD = 1; rsD = 3; WriteRegM = 3; RegWriteM = 1;
    step("br_alu_m_fwd", 0, 1, 0, 2'b00, 2'b00, 0, 0);
    idle(); BranchD = 1; MemtoRegM = 1; RegWriteM = 1; WriteRegM = 9; rtD = 9;
    step("br_load_m", 1, 0, 1, 2'b00, 2'b00, 0, 1);
    idle(); RegWriteE = 1; WriteRegE = 3; rsD = 3;
    step("no_branch", 0, 0, 0, 2'b00, 2'b00, 0, 0);
    idle(); MemtoRegE = 1; rtE = 6; rsD = 6; BranchD = 1; RegWriteE = 1; WriteRegE = 6;
    step("both_stalls", 1, 0, 0, 2'b00, 2'b00, 1, 1);

    // Asynchronous reset asserted between clock edges while a stall is held.
    idle(); MemtoRegE = 1; rtE = 8; rtD = 8;
    #2 reset = 1'b0;
    lw_exp = '0; br_exp = '0; sat_lw_exp = '0; sat_br_exp = '0;
    #1;
    push_ctrl("async_reset", 0, 0, 0, 2'b00, 2'b00);
    check();
    push_cnt("async_reset");
    check();
    idle();
    reset = 1'b1;

    for (int i = 0; i < 5; i++) begin
      idle(); MemtoRegE = 1; rtE = 8; rtD = 8;
      step($sformatf("sat_lw_%0d", i), 1, 0, 0, 2'b00, 2'b00, 1, 0);
    end

    idle();
    step("final_idle", 0, 0, 0, 2'b00, 2'b00, 0, 0);

    if (sb.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
